// File: rtl/std_types.sv
// Shared scalar typedefs and width constants for the math datapath library.
package std_types;

  typedef logic       bool;
  typedef logic [7:0] u8;
  typedef logic [15:0] u16;

  localparam int U8  = 8;
  localparam int U16 = 16;

endpackage

// File: rtl/usub_comb.sv
// Combinational unsigned saturating subtract: out = max(in0 - in1, 0), with
// underflow magnitude and flag. Port-compatible with the saturating adder.
module usub_comb
  import std_types::*;
#(
  parameter int DATA_WIDTH = U8
) (
  input  logic [DATA_WIDTH-1:0] in0,
  input  logic [DATA_WIDTH-1:0] in1,
  output logic [DATA_WIDTH-1:0] out,
  output logic [DATA_WIDTH-1:0] underflow,
  output logic                  sig_uf
);

  logic [DATA_WIDTH:0] diff;
  logic [DATA_WIDTH:0] neg;

  always_comb begin
    diff   = {1'b0, in0} - {1'b0, in1};
    // Negating the wide difference yields in1 - in0 whenever a borrow occurred.
    neg    = '0 - diff;
    sig_uf = diff[DATA_WIDTH];
    if (diff[DATA_WIDTH]) begin
      out       = '0;
      underflow = neg[DATA_WIDTH-1:0];
    end else begin
      out       = diff[DATA_WIDTH-1:0];
      underflow = '0;
    end
  end

endmodule

// File: rtl/usub_pipe.sv
// Two-stage valid/ready pipelined saturating subtractor with sticky underflow
// status and a saturating underflow event counter.
module usub_pipe
  import std_types::*;
#(
  parameter int DATA_WIDTH = U8,
  parameter int CNT_WIDTH  = U16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in0,
  input  logic [DATA_WIDTH-1:0] in1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out,
  output logic [DATA_WIDTH-1:0] underflow,
  output logic                  sig_uf,
  output logic                  uf_sticky,
  output logic [CNT_WIDTH-1:0]  uf_count,
  input  logic                  clr_status
);

  logic                  s1_valid;
  logic                  s2_valid;
  logic [DATA_WIDTH-1:0] s1_a;
  logic [DATA_WIDTH-1:0] s1_b;
  logic [DATA_WIDTH-1:0] c_out;
  logic [DATA_WIDTH-1:0] c_uf;
  logic                  c_sig;
  bool                   adv1;
  bool                   adv2;
  bool                   uf_xfer;

  assign adv2      = !s2_valid || out_ready;
  assign adv1      = !s1_valid || adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_valid;
  assign uf_xfer   = s2_valid && out_ready && sig_uf;

  usub_comb #(.DATA_WIDTH(DATA_WIDTH)) u_comb (
    .in0       (s1_a),
    .in1       (s1_b),
    .out       (c_out),
    .underflow (c_uf),
    .sig_uf    (c_sig)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s2_valid  <= 1'b0;
      out       <= '0;
      underflow <= '0;
      sig_uf    <= 1'b0;
    end else begin
      if (adv1) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_a <= in0;
          s1_b <= in1;
        end
      end
      if (adv2) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out       <= c_out;
          underflow <= c_uf;
          sig_uf    <= c_sig;
        end
      end
    end
  end

  // A clear that coincides with an underflow delivery still records that event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uf_sticky <= 1'b0;
      uf_count  <= '0;
    end else if (clr_status) begin
      uf_sticky <= uf_xfer;
      uf_count  <= uf_xfer ? CNT_WIDTH'(1) : '0;
    end else if (uf_xfer) begin
      uf_sticky <= 1'b1;
      if (uf_count != '1) uf_count <= uf_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_usub_pipe.sv
// Scoreboard bench for usub_pipe: driver pushes expected results, monitor pops
// and compares on every output transfer.
module tb_usub_pipe;

  typedef struct {
    logic [7:0] o;
    logic [7:0] u;
    logic       s;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in0;
  logic [7:0]  in1;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out;
  logic [7:0]  underflow;
  logic        sig_uf;
  logic        uf_sticky;
  logic [15:0] uf_count;
  logic        clr_status;

  logic        in_ready2;
  logic        out_valid2;
  logic [7:0]  out2;
  logic [7:0]  underflow2;
  logic        sig_uf2;
  logic        uf_sticky2;
  logic [1:0]  uf_count2;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [7:0]  va[64];
  logic [7:0]  vb[64];
  logic        saw_stall;

  always #5 clk = ~clk;

  usub_pipe #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in0(in0), .in1(in1), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .underflow(underflow), .sig_uf(sig_uf),
    .uf_sticky(uf_sticky), .uf_count(uf_count), .clr_status(clr_status)
  );

  usub_pipe #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in0(in0), .in1(in1), .out_valid(out_valid2), .out_ready(out_ready),
    .out(out2), .underflow(underflow2), .sig_uf(sig_uf2),
    .uf_sticky(uf_sticky2), .uf_count(uf_count2), .clr_status(clr_status)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    if (a >= b) begin
      e.o = a - b; e.u = 8'd0; e.s = 1'b0;
    end else begin
      e.o = 8'd0;  e.u = b - a; e.s = 1'b1;
    end
    return e;
  endfunction

  // Monitor: decides at mid-low-phase whether the next rising edge transfers.
  initial begin
    logic held;
    exp_t hv;
    exp_t e;
    held = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        held = 1'b0;
        continue;
      end
      if (held) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_out", out, hv.o);
        chk("hold_underflow", underflow, hv.u);
        chk("hold_sig_uf", sig_uf, hv.s);
      end
      held = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          chk("result_expected", q.size() != 0, 1);
          if (q.size() != 0) begin
            e = q.pop_front();
            chk("res_out", out, e.o);
            chk("res_underflow", underflow, e.u);
            chk("res_sig_uf", sig_uf, e.s);
          end
        end else begin
          held = 1'b1;
          hv.o = out; hv.u = underflow; hv.s = sig_uf;
        end
      end
    end
  end

  task automatic send1(input logic [7:0] a, input logic [7:0] b, input logic [7:0] eo,
                       input logic [7:0] eu, input logic es, input logic clr_at_xfer);
    exp_t e;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in0 = a;
    in1 = b;
    e.o = eo; e.u = eu; e.s = es;
    q.push_back(e);
    #1 chk("idle_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("latency_not_early", out_valid, 0);
    @(negedge clk);
    chk("latency_two", out_valid, 1);
    if (clr_at_xfer) clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
  endtask

  // mode 0: out_ready high, 1: out_ready low on cycles 3-6, 2: random out_ready
  task automatic run_stream(input int n, input int mode);
    int i = 0;
    int c = 0;
    saw_stall = 1'b0;
    while (i < n && c < 4000) begin
      @(negedge clk);
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = !(c >= 3 && c <= 6);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      in_valid = 1'b1;
      in0 = va[i];
      in1 = vb[i];
      #1;
      if (!in_ready) saw_stall = 1'b1;
      else begin
        q.push_back(model(va[i], vb[i]));
        i++;
      end
      c++;
    end
    chk("stream_all_accepted", i, n);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic drain();
    int c = 0;
    out_ready = 1'b1;
    while (q.size() != 0 && c < 300) begin
      @(negedge clk);
      c++;
    end
    chk("drain_done", q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] sa[10];
    logic [7:0] sb[10];
    logic [1:0] small_seq[5];
    sa = '{8'd10, 8'd3, 8'd255, 8'd0, 8'd128, 8'd100, 8'd1, 8'd90, 8'd250, 8'd5};
    sb = '{8'd3, 8'd10, 8'd0, 8'd0, 8'd129, 8'd1, 8'd100, 8'd90, 8'd5, 8'd250};
    small_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    in_valid = 1'b0; in0 = '0; in1 = '0; out_ready = 1'b1; clr_status = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out", out, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_sig_uf", sig_uf, 0);
    chk("rst_sticky", uf_sticky, 0);
    chk("rst_count", uf_count, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    send1(8'd200, 8'd50, 8'd150, 8'd0, 1'b0, 1'b0);
    chk("cnt_after_200_50", uf_count, 0);
    chk("sticky_after_200_50", uf_sticky, 0);
    send1(8'd50, 8'd200, 8'd0, 8'd150, 1'b1, 1'b0);
    chk("cnt_after_50_200", uf_count, 1);
    chk("sticky_after_50_200", uf_sticky, 1);
    send1(8'd0, 8'd255, 8'd0, 8'd255, 1'b1, 1'b0);
    chk("cnt_after_0_255", uf_count, 2);
    send1(8'd77, 8'd77, 8'd0, 8'd0, 1'b0, 1'b0);
    chk("cnt_after_77_77", uf_count, 2);

    for (int k = 0; k < 10; k++) begin
      va[k] = sa[k];
      vb[k] = sb[k];
    end
    run_stream(10, 1);
    chk("stall_in_ready_dropped", saw_stall, 1);
    drain();
    chk("cnt_after_stream", uf_count, 6);
    chk("small_cnt_saturated", uf_count2, 3);

    @(negedge clk);
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    chk("clr_count", uf_count, 0);
    chk("clr_sticky", uf_sticky, 0);
    chk("clr_small_count", uf_count2, 0);

    for (int k = 0; k < 5; k++) begin
      send1(8'd9, 8'd10, 8'd0, 8'd1, 1'b1, 1'b0);
      chk("small_cnt_seq", uf_count2, small_seq[k]);
      chk("big_cnt_seq", uf_count, k + 1);
    end

    send1(8'd0, 8'd1, 8'd0, 8'd1, 1'b1, 1'b1);
    chk("clr_coincident_count", uf_count, 1);
    chk("clr_coincident_sticky", uf_sticky, 1);
    chk("clr_coincident_small", uf_count2, 1);

    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in0 = 8'd40; in1 = 8'd4;
    q.push_back(model(8'd40, 8'd4));
    @(negedge clk);
    in0 = 8'd4; in1 = 8'd40;
    q.push_back(model(8'd4, 8'd40));
    @(negedge clk);
    in0 = 8'd7; in1 = 8'd8;
    q.push_back(model(8'd7, 8'd8));
    #3 rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_count", uf_count, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_sticky", uf_sticky, 0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send1(8'd30, 8'd10, 8'd20, 8'd0, 1'b0, 1'b0);
    chk("postrst_count", uf_count, 0);

    for (int k = 0; k < 40; k++) begin
      va[k] = 8'($urandom_range(0, 255));
      vb[k] = 8'($urandom_range(0, 255));
    end
    va[0] = 8'd255; vb[0] = 8'd255;
    va[1] = 8'd0;   vb[1] = 8'd1;
    run_stream(40, 2);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
